// File: rtl/dac_tx_pkg.sv
// rtl/dac_tx_pkg.sv - shared types and constants for the DAC FIFO/SPI transmitter
package dac_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    localparam logic SCLK_IDLE = 1'b0;
    localparam logic SYNC_IDLE = 1'b1;

    // Fill must represent 0..depth inclusive, hence one bit beyond the pointer width.
    function automatic int fill_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO with flush
module sync_fifo_fwft #(
    parameter int DW    = 24,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   write,
    input  logic [DW-1:0]          write_data,
    input  logic                   pop,
    output logic                   full,
    output logic [$clog2(DEPTH):0] fill,
    output logic [DW-1:0]          head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pull;
    logic [AW:0]   fill_nxt;

    // Full is the registered flag, so a same-cycle pop never rescues a write at full.
    assign push      = write & ~full & ~clear;
    assign pull      = pop & (fill != '0) & ~clear;
    assign fill_nxt  = fill + (AW+1)'(push) - (AW+1)'(pull);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            full   <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pull) rd_ptr <= rd_ptr + AW'(1);
            fill <= fill_nxt;
            full <= (fill_nxt == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= write_data;
    end

endmodule

// File: rtl/dac_fifo_spi_tx.sv
// rtl/dac_fifo_spi_tx.sv - sample FIFO feeding a tick-paced MSB-first serial DAC link
module dac_fifo_spi_tx
    import dac_tx_pkg::*;
#(
    parameter int pDAC_DW     = 24,
    parameter int pFIFO_DEPTH = 16,
    parameter int pSCLK_DIV   = 4,
    parameter int pSAMPLE_DIV = 1024
) (
    input  logic                                  iclk,
    input  logic                                  irst,
    input  logic                                  dac_rst,
    input  logic                                  dac_write,
    input  logic [pDAC_DW-1:0]                    dac_write_data,
    output logic                                  dac_full,
    input  logic                                  dac_clear,
    output logic                                  odac_sclk,
    output logic                                  odac_sync_n,
    output logic                                  odac_sdo,
    output logic [fill_width(pFIFO_DEPTH)-1:0]    ofill,
    output logic                                  ounderrun,
    output logic                                  ooverflow
);

    localparam int CW = $clog2(pSAMPLE_DIV);
    localparam int PW = $clog2(2 * pSCLK_DIV);
    localparam int BW = $clog2(pDAC_DW);

    localparam logic [PW-1:0] LAST_PHASE = PW'(2 * pSCLK_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'(pSCLK_DIV - 1);
    localparam logic [PW-1:0] HALF       = PW'(pSCLK_DIV);

    logic [CW-1:0]      sample_cnt;
    logic               tick;
    logic [pDAC_DW-1:0] head;
    logic [pDAC_DW-1:0] hold;
    logic               fifo_empty;
    logic               take;
    logic               starve;

    tx_state_t          state, state_nxt;
    logic [PW-1:0]      phase, phase_nxt;
    logic [BW-1:0]      bit_cnt, bit_nxt;
    logic [pDAC_DW-1:0] shreg, shreg_nxt;
    logic               sclk_nxt, sync_nxt, sdo_nxt;

    assign tick       = (sample_cnt == CW'(pSAMPLE_DIV - 1));
    assign fifo_empty = (ofill == '0);
    assign take       = (state == IDLE) && tick && !fifo_empty;
    assign starve     = (state == IDLE) && tick && fifo_empty;

    sync_fifo_fwft #(
        .DW    (pDAC_DW),
        .DEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk        (iclk),
        .rst        (irst),
        .clear      (dac_clear | dac_rst),
        .write      (dac_write),
        .write_data (dac_write_data),
        .pop        (take),
        .full       (dac_full),
        .fill       (ofill),
        .head_data  (head)
    );

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            sample_cnt <= '0;
            hold       <= '0;
            ounderrun  <= 1'b0;
            ooverflow  <= 1'b0;
        end else if (dac_rst) begin
            sample_cnt <= '0;
            hold       <= '0;
            ounderrun  <= 1'b0;
            ooverflow  <= 1'b0;
        end else begin
            sample_cnt <= tick ? '0 : sample_cnt + CW'(1);
            if (take) hold <= head;
            if (dac_clear) begin
                ounderrun <= 1'b0;
                ooverflow <= 1'b0;
            end else begin
                if (starve) ounderrun <= 1'b1;
                if (dac_write && dac_full) ooverflow <= 1'b1;
            end
        end
    end

    // Pins are registered from the next-state values so each output is a plain flop.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state       <= IDLE;
            phase       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            odac_sclk   <= SCLK_IDLE;
            odac_sync_n <= SYNC_IDLE;
            odac_sdo    <= 1'b0;
        end else if (dac_rst) begin
            state       <= IDLE;
            phase       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            odac_sclk   <= SCLK_IDLE;
            odac_sync_n <= SYNC_IDLE;
            odac_sdo    <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            bit_cnt     <= bit_nxt;
            shreg       <= shreg_nxt;
            odac_sclk   <= sclk_nxt;
            odac_sync_n <= sync_nxt;
            odac_sdo    <= sdo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SHIFT;
                    phase_nxt = '0;
                    bit_nxt   = BW'(pDAC_DW - 1);
                    shreg_nxt = fifo_empty ? hold : head;
                end
            end
            SHIFT: begin
                if (phase == LAST_PHASE) begin
                    phase_nxt = '0;
                    if (bit_cnt == '0) begin
                        state_nxt = GAP;
                    end else begin
                        bit_nxt   = bit_cnt - BW'(1);
                        shreg_nxt = {shreg[pDAC_DW-2:0], 1'b0};
                    end
                end else begin
                    phase_nxt = phase + PW'(1);
                end
            end
            GAP: begin
                if (phase == GAP_LAST) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + PW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sclk_nxt = SCLK_IDLE;
        sync_nxt = SYNC_IDLE;
        sdo_nxt  = 1'b0;
        if (state_nxt == SHIFT) begin
            sync_nxt = ~SYNC_IDLE;
            sclk_nxt = (phase_nxt < HALF);
            sdo_nxt  = shreg_nxt[pDAC_DW-1];
        end
    end

endmodule

// File: doc/dac_fifo_spi_tx.md
Name: dac_fifo_spi_tx

Overview:
Downstream stage of the ADC→FIR→DAC processing chain. It accepts filtered samples through the DAC write interface (write/full/clear/rst) and buffers them in a small FIFO. At a fixed sample-rate tick it pops one sample and shifts it out MSB-first to an external serial DAC over a 3-wire SPI-style link (SCLK, SYNC_n, SDO). When no sample is ready it replays the last one and flags the underrun.

Parameters:
pDAC_DW, 24, sample width in bits; also the SPI frame length.
pFIFO_DEPTH, 16, FIFO entries; must be a power of 2, ≥ 2.
pSCLK_DIV, 4, iclk cycles per SCLK half-period; ≥ 1.
pSAMPLE_DIV, 1024, iclk cycles per output sample; must be ≥ 2*pSCLK_DIV*pDAC_DW + pSCLK_DIV + 2.

Ports:
iclk  in  1  system clock; all logic on its rising edge.
irst  in  1  asynchronous, active-high reset.
dac_rst  in  1  synchronous soft reset, active high; same effect as irst.
dac_write  in  1  write strobe; one sample per asserted cycle.
dac_write_data  in  pDAC_DW  sample, two's complement.
dac_full  out  1  FIFO full; writes while high are dropped.
dac_clear  in  1  synchronous FIFO flush and sticky-flag clear.
odac_sclk  out  1  serial clock to the DAC; idles low.
odac_sync_n  out  1  frame select, active low.
odac_sdo  out  1  serial data, MSB first.
ofill  out  $clog2(pFIFO_DEPTH)+1  current FIFO occupancy.
ounderrun  out  1  sticky: a tick found the FIFO empty.
ooverflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (irst or dac_rst):
  - All outputs go to sclk=0, sync_n=1, sdo=0, full=0, fill=0, underrun=0, overflow=0.
  - FIFO pointers, sample counter, hold register (0) and FSM (IDLE) are cleared.
  - A reset mid-frame aborts the frame immediately; no partial completion.
- FIFO:
  - Synchronous, first-word-fall-through. Head data is valid in the same cycle fill>0.
  - dac_full = (fill == pFIFO_DEPTH), registered with fill.
  - A write when full is dropped and sets ooverflow, even if a pop occurs in the same cycle.
  - A write and a pop in the same cycle with 0<fill<DEPTH leaves fill unchanged.
  - A write while empty in the tick cycle is stored; the tick still counts as an underrun.
- dac_clear:
  - Sets fill to 0 and clears ounderrun and ooverflow.
  - Has priority over a same-cycle write, which is discarded.
  - Does not abort a frame in progress.
- Sample counter: free-runs 0..pSAMPLE_DIV-1. tick = (count == pSAMPLE_DIV-1).
- FSM states: IDLE, SHIFT, GAP.
  - IDLE:
    - On tick with fill>0: load the shift register from the FIFO head, pop, copy the sample into the hold register, go to SHIFT.
    - On tick with fill==0: load the shift register from the hold register, set ounderrun, go to SHIFT.
    - A tick outside IDLE cannot occur, given the parameter constraint.
  - SHIFT:
    - sync_n=0. The bit counter runs pDAC_DW-1 down to 0.
    - Each bit lasts 2*pSCLK_DIV cycles: sdo is stable for the whole bit, sclk is high for the first pSCLK_DIV cycles and low for the second. The DAC samples on the falling edge, mid-bit.
    - After bit 0 completes, go to GAP.
  - GAP: sync_n=1, sclk=0, sdo=0 for pSCLK_DIV cycles, then IDLE.
- Timing and outputs:
  - Latency: the first sclk rising edge appears 1 cycle after the tick cycle. One frame takes 2*pSCLK_DIV*pDAC_DW cycles of sync_n low.
  - All serial outputs come straight from flops; no combinational paths to pins.
  - Data is sent unmodified; no width conversion or saturation inside this block.

Decomposition:
- Package dac_tx_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - the idle-level constants (SCLK_IDLE=0, SYNC_IDLE=1);
  - a width function returning $clog2(depth)+1 for the fill port.
- Sub-module sync_fifo_fwft (parameters DW, DEPTH) provides write, pop, clear, full, fill and head data.
- The top level holds the sample counter, FSM, bit/half-period counters and the shift and hold registers.

Test Plan:
- Reset check: with pDAC_DW=24, pSCLK_DIV=2, pSAMPLE_DIV=128, hold irst, then release → sync_n=1, sclk=0, fill=0, flags 0. The first tick with an empty FIFO sends 0x000000 and sets ounderrun=1.
- Single sample: write 0xA5C3F0, wait for the tick → sync_n low for exactly 96 cycles, 24 sclk falling edges, sampled bits = 0xA5C3F0 MSB-first, fill goes 1→0 in the tick cycle.
- Overflow: write 17 samples back-to-back with DEPTH=16 → dac_full=1 after the 16th, the 17th is dropped, ooverflow=1. dac_clear then gives fill=0 and ooverflow=0.
- Underrun replay: write only 0x123456, run 3 ticks → frames are 0x123456, 0x123456, 0x123456; ounderrun=1 from the second tick onward.
- Mid-frame abort: assert dac_rst at bit 10 of a frame → the next cycle has sync_n=1 and sclk=0; the next frame starts cleanly at the next tick with fill=0.
- Simultaneous events: pop and write in the tick cycle at fill=5 → fill stays 5. dac_clear together with dac_write → fill=0 and the written sample is absent.
